imem_loader: RTL

Loads a program into the core's instruction memory from a byte stream at run time, replacing the fixed power-up image. Sits between a byte source (UART receiver, debug bridge) and the write side of a writable instruction memory. While loading, it holds the core in reset. Words are assembled little-endian and written to consecutive word addresses starting at 0.

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_loader.sv | 126 ++++++++++++
 2 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory byte-stream loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_e;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader.sv
// Streams a length-prefixed little-endian program into instruction memory while holding the core in reset.
// One write cycle per word, 3 + 5N cycles minimum; byte_ready drops during the write cycle and in IDLE/DONE/ERR.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        we,
  output logic [31:0] wa,
  output logic [31:0] wd,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  localparam int IDX_W = $clog2(DEPTH + 1);
  localparam int NW    = 8 * HDR_BYTES;
  localparam int BC_W  = $clog2(WORD_BYTES);

  state_e            state_q, state_d;
  logic [NW-1:0]     n_q, n_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [BC_W-1:0]   bcnt_q, bcnt_d;
  logic [31:0]       word_q, word_d;
  logic [31:0]       wa_q, wa_d;
  logic [31:0]       wd_q, wd_d;
  logic              fire;
  logic [NW-1:0]     n_full;

  assign byte_ready = (state_q == S_LEN0) || (state_q == S_LEN1) || (state_q == S_DATA);
  assign fire       = byte_valid && byte_ready;
  assign n_full     = {byte_data, n_q[7:0]};

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    wa_d    = wa_q;
    wd_d    = wd_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN0;
          idx_d   = '0;
          bcnt_d  = '0;
        end
      end
      S_LEN0: begin
        if (fire) begin
          n_d[7:0] = byte_data;
          state_d  = S_LEN1;
        end
      end
      S_LEN1: begin
        if (fire) begin
          n_d = n_full;
          if (n_full == '0) begin
            state_d = S_DONE;
          end else if (n_full > NW'(DEPTH)) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (fire) begin
          word_d[{bcnt_q, 3'b000} +: 8] = byte_data;
          bcnt_d = bcnt_q + 1'b1;
          // Capture the completed word so wa/wd are stable throughout the write cycle.
          if (bcnt_q == BC_W'(WORD_BYTES - 1)) begin
            state_d = S_WRITE;
            wa_d    = 32'(idx_q) << 2;
            wd_d    = word_d;
          end
        end
      end
      S_WRITE: begin
        if (NW'(idx_q) == n_q - 1'b1) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_DATA;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      wa_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
    end
  end

  assign we       = (state_q == S_WRITE);
  assign wa       = wa_q;
  assign wd       = wd_q;
  assign done     = (state_q == S_DONE);
  assign err      = (state_q == S_ERR);
  assign cpu_hold = (state_q == S_LEN0) || (state_q == S_LEN1) || (state_q == S_DATA) ||
                    (state_q == S_WRITE) || (state_q == S_ERR);

endmodule
